// File: rtl/air_hockey_pkg.sv
// Shared air-hockey constants: screen geometry, object radii, the player 2
// FSM state encoding and the derived player 2 position limits.
package air_hockey_pkg;

  localparam int SCREEN_W       = 1024;
  localparam int SCREEN_H       = 768;
  localparam int PLAYERS_RADIUS = 20;
  localparam int RADIUS_BALL    = 10;

  localparam int MID_X = SCREEN_W / 2;
  localparam int X_MIN = MID_X + PLAYERS_RADIUS;          // 532
  localparam int X_MAX = SCREEN_W - 1 - PLAYERS_RADIUS;   // 1003
  localparam int Y_MIN = PLAYERS_RADIUS;                  // 20
  localparam int Y_MAX = SCREEN_H - 1 - PLAYERS_RADIUS;   // 747

  typedef enum logic [1:0] {
    ST_HOME    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_ATTACK  = 2'd2,
    ST_RETREAT = 2'd3
  } state_t;

endpackage

// File: rtl/axis_stepper.sv
// One axis of the player 2 position. Clamps the requested target into
// [lo,hi], then moves the registered position toward it by at most MAX_STEP
// pixels on each tick.
//   clk_in  : pixel clock
//   rst     : asynchronous active-low reset, pos <= RESET_VAL
//   tick    : one-cycle frame strobe; pos only moves when high
//   target  : 13-bit unsigned requested position (may exceed 12 bits)
//   lo, hi  : inclusive limits for this axis
//   pos     : registered position
module axis_stepper #(
  parameter int RESET_VAL = 0,
  parameter int MAX_STEP  = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        tick,
  input  logic [12:0] target,
  input  logic [11:0] lo,
  input  logic [11:0] hi,
  output logic [11:0] pos
);

  localparam logic [11:0] STEP = 12'(MAX_STEP);

  logic [11:0]        r_pos;
  logic [12:0]        w_tgt_c;
  logic signed [12:0] w_diff;
  logic [12:0]        w_mag;
  logic [11:0]        w_step;
  logic [11:0]        w_next;

  always_comb begin
    w_tgt_c = target;
    if (target < {1'b0, lo})
      w_tgt_c = {1'b0, lo};
    else if (target > {1'b0, hi})
      w_tgt_c = {1'b0, hi};
  end

  // Both operands are below 4096 after the clamp, so the 13-bit signed
  // difference cannot overflow.
  assign w_diff = $signed(w_tgt_c) - $signed({1'b0, r_pos});
  assign w_mag  = w_diff[12] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_step = (w_mag > {1'b0, STEP}) ? STEP : w_mag[11:0];
  assign w_next = w_diff[12] ? (r_pos - w_step) : (r_pos + w_step);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)
      r_pos <= 12'(RESET_VAL);
    else if (tick)
      r_pos <= w_next;
  end

  assign pos = r_pos;

endmodule

// File: rtl/player2_ai_ctl.sv
// Computer-controlled player 2 paddle. Once per frame (vsync rising edge)
// picks a target from the ball position and FSM state, then steps the
// paddle toward it, rate-limited and clamped to the right half of the table.
//   clk_in          : 65 MHz pixel clock
//   rst             : asynchronous active-low reset
//   vsync_in        : rising edge starts a new frame
//   xpos_ball/ypos_ball : ball centre
//   player_1_score/player_2_score : any change is treated as a goal
//   xpos_out/ypos_out   : player 2 centre
//   state_out       : current FSM state
//
// state   | meaning
// HOME    | sit at home for HOLD_FRAMES frames (after reset or a goal)
// TRACK   | stay at HOME_X, follow the ball in y
// ATTACK  | chase a point just right of the ball, pushing it left
// RETREAT | return home, then resume tracking
module player2_ai_ctl
  import air_hockey_pkg::*;
#(
  parameter int HOME_X        = 900,
  parameter int HOME_Y        = 384,
  parameter int MAX_STEP      = 4,
  parameter int HOLD_FRAMES   = 60,
  parameter int ATTACK_FRAMES = 90
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic [11:0] xpos_ball,
  input  logic [11:0] ypos_ball,
  input  logic [3:0]  player_1_score,
  input  logic [3:0]  player_2_score,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic [1:0]  state_out
);

  localparam int CNT_MAX = (HOLD_FRAMES > ATTACK_FRAMES) ? HOLD_FRAMES : ATTACK_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             r_vsync_prev;
  logic [3:0]       r_p1_prev;
  logic [3:0]       r_p2_prev;
  logic             r_goal;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [CNT_W-1:0] r_atk;
  logic [CNT_W-1:0] w_atk_nxt;
  logic             w_tick;
  logic             w_score_chg;
  logic             w_at_home;
  logic [12:0]      w_tgt_x;
  logic [12:0]      w_tgt_y;

  assign w_tick      = vsync_in & ~r_vsync_prev;
  assign w_score_chg = (player_1_score != r_p1_prev) | (player_2_score != r_p2_prev);
  // Uses the pre-update position: arrival is seen one tick after reaching home.
  assign w_at_home   = (xpos_out == 12'(HOME_X)) && (ypos_out == 12'(HOME_Y));

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_vsync_prev <= 1'b0;
      r_p1_prev    <= '0;
      r_p2_prev    <= '0;
      r_goal       <= 1'b0;
      r_state      <= ST_HOME;
      r_hold       <= CNT_W'(HOLD_FRAMES);
      r_atk        <= '0;
    end else begin
      r_vsync_prev <= vsync_in;
      r_p1_prev    <= player_1_score;
      r_p2_prev    <= player_2_score;
      // Sticky until the next frame tick, so a burst of score changes in one
      // frame collapses into a single goal event.
      r_goal       <= w_score_chg | (r_goal & ~w_tick);
      if (w_tick) begin
        r_state <= w_state_nxt;
        r_hold  <= w_hold_nxt;
        r_atk   <= w_atk_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_atk_nxt   = r_atk;
    w_tgt_x     = 13'(HOME_X);
    w_tgt_y     = 13'(HOME_Y);
    case (r_state)
      ST_HOME: begin
        w_hold_nxt = (r_hold == '0) ? '0 : r_hold - CNT_W'(1);
        if (w_hold_nxt == '0)
          w_state_nxt = ST_TRACK;
      end
      ST_TRACK: begin
        w_tgt_y = {1'b0, ypos_ball};
        if (xpos_ball >= 12'(MID_X)) begin
          w_state_nxt = ST_ATTACK;
          w_atk_nxt   = CNT_W'(ATTACK_FRAMES);
        end
      end
      ST_ATTACK: begin
        // 13-bit sum so a ball near the right edge does not wrap.
        w_tgt_x   = {1'b0, xpos_ball} + 13'(RADIUS_BALL + PLAYERS_RADIUS);
        w_tgt_y   = {1'b0, ypos_ball};
        w_atk_nxt = (r_atk == '0) ? '0 : r_atk - CNT_W'(1);
        if ((xpos_ball < 12'(MID_X)) || (w_atk_nxt == '0))
          w_state_nxt = ST_RETREAT;
      end
      ST_RETREAT: begin
        if (w_at_home)
          w_state_nxt = ST_TRACK;
      end
      default: w_state_nxt = ST_HOME;
    endcase
    if (r_goal) begin
      w_state_nxt = ST_HOME;
      w_hold_nxt  = CNT_W'(HOLD_FRAMES);
    end
  end

  axis_stepper #(.RESET_VAL(HOME_X), .MAX_STEP(MAX_STEP)) u_step_x (
    .clk_in (clk_in),
    .rst    (rst),
    .tick   (w_tick),
    .target (w_tgt_x),
    .lo     (12'(X_MIN)),
    .hi     (12'(X_MAX)),
    .pos    (xpos_out)
  );

  axis_stepper #(.RESET_VAL(HOME_Y), .MAX_STEP(MAX_STEP)) u_step_y (
    .clk_in (clk_in),
    .rst    (rst),
    .tick   (w_tick),
    .target (w_tgt_y),
    .lo     (12'(Y_MIN)),
    .hi     (12'(Y_MAX)),
    .pos    (ypos_out)
  );

  assign state_out = r_state;

endmodule
